// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with a run-time programmable pattern of
// 1..MAX_LEN bits, overlapping or non-overlapping detection, a registered
// one-cycle match flag and a saturating match counter.
module seq_detector_param #(
  parameter int MAX_LEN = 8,   // maximum pattern length in bits (2..16)
  parameter int LEN_W   = 5,   // width of length fields, must hold MAX_LEN
  parameter int CNT_W   = 8    // width of the match counter
) (
  input  logic               clk,
  input  logic               rst,          // asynchronous, active-low
  input  logic               k,
  input  logic               k_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   fill
);

  localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  // Latched configuration
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;

  // Detection state
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_z;
  logic [CNT_W-1:0]   r_cnt;

  // Next-state helpers
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic [LEN_W-1:0]   w_len_clamped;

  // Shift in the new bit, compare the youngest len bits against the pattern.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_hist_next   = {r_hist[MAX_LEN-2:0], k};
    w_fill_next   = (r_fill >= LP_MAX_LEN) ? LP_MAX_LEN : r_fill + LEN_W'(1);
    w_mask        = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      // Pattern bits at or above len are don't-care.
      w_mask[i] = (i < int'(r_len));
    end
    w_hit         = (r_len != '0) &&
                    (w_fill_next >= r_len) &&
                    (((w_hist_next ^ r_pattern) & w_mask) == '0);
    w_len_clamped = (cfg_len > LP_MAX_LEN) ? LP_MAX_LEN : cfg_len;
  end

  // Config latch, history/fill tracking, registered match flag and counter.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    if (!rst) begin
      // The config registers are plain flops (no memory array), so they
      // are reset like the rest of the state: len=0 keeps matching off.
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b1;
      r_hist    <= '0;
      r_fill    <= '0;
      r_z       <= 1'b0;
      r_cnt     <= '0;
    end else if (cfg_load) begin
      // A new config restarts detection; the bit in this cycle is dropped.
      r_pattern <= cfg_pattern;
      r_len     <= w_len_clamped;
      r_overlap <= cfg_overlap;
      r_hist    <= '0;
      r_fill    <= '0;
      r_z       <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (k_valid) begin
        r_hist <= w_hist_next;
        // Non-overlapping mode forgets the bits that formed the match.
        r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_next;
        r_z    <= w_hit;
      end else begin
        r_z    <= 1'b0;
      end

      // Clear wins over a coincident hit; otherwise count up to saturation.
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (k_valid && w_hit && (r_cnt != LP_CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign z         = r_z;
  assign match_cnt = r_cnt;
  assign fill      = r_fill;

endmodule
